// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// Define ARB_RR_EN to alternate grants under contention instead of the default fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic [DW-1:0] IRData,
  output logic          IValid,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic [DW-1:0] DRData,
  output logic          DValid,
  output logic          StallF,
  output logic          StallM,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t        state, stateNext;
  logic          ownerD;
  logic [AW-1:0] addrReg;
  logic          weReg;
  logic [DW-1:0] wdataReg;
  logic [CW-1:0] cntReg;
  logic [DW-1:0] rdataReg;
  logic          anyReq;
  logic          grantD;
  logic          inIssue;
  logic          inResp;

  assign anyReq = IReq | DReq;

`ifdef ARB_RR_EN
  logic lastD;

  // Under contention, D wins only if I was granted last; single requests always win.
  assign grantD = DReq & (~IReq | ~lastD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastD <= 1'b0;
    end else if (state == IDLE && anyReq) begin
      lastD <= grantD;
    end
  end
`else
  assign grantD = DReq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   stateNext = weReg ? RESP : WAIT;
      WAIT:    if (cntReg == '0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ownerD   <= 1'b0;
      addrReg  <= '0;
      weReg    <= 1'b0;
      wdataReg <= '0;
      cntReg   <= '0;
      rdataReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerD   <= grantD;
            addrReg  <= grantD ? DAddr : IAddr;
            weReg    <= grantD & DWe;
            wdataReg <= grantD ? DWData : '0;
          end
        end
        ISSUE: cntReg <= CW'(LAT - 1);
        WAIT: begin
          if (cntReg == '0) begin
            rdataReg <= MemRData;
          end else begin
            cntReg <= cntReg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign inIssue = (state == ISSUE);
  assign inResp  = (state == RESP);

  // Memory-side outputs are forced to zero outside the single issue cycle.
  assign MemEn    = inIssue;
  assign MemWe    = inIssue & weReg;
  assign MemAddr  = inIssue ? addrReg : '0;
  assign MemWData = (inIssue & weReg) ? wdataReg : '0;

  // A requester that dropped its Req before RESP has been flushed: no completion pulse.
  assign IValid = inResp & ~ownerD & IReq;
  assign DValid = inResp & ownerD & DReq;
  assign IRData = IValid ? rdataReg : '0;
  assign DRData = DValid ? rdataReg : '0;

  assign StallF = IReq & ~IValid;
  assign StallM = DReq & ~DValid;
  assign Busy   = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes) of the 16-bit pipelined processor.
- Serialises requests through a small FSM, absorbs the fixed memory latency, and raises StallF/StallM so the hazard logic freezes the affected stages.
- Sits between the pipeline datapath and the memory macro.

Parameters:
AW, 16, address width
DW, 16, data width
LAT, 2, memory read latency in cycles from MemEn edge to MemRData valid (LAT >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
IReq  input  1  fetch read request, held until IValid
IAddr  input  AW  fetch address
IRData  output  DW  fetched instruction, valid while IValid
IValid  output  1  one-cycle fetch completion pulse
DReq  input  1  data request, held until DValid
DWe  input  1  1 = write, 0 = read
DAddr  input  AW  data address
DWData  input  DW  write data
DRData  output  DW  read data, valid while DValid
DValid  output  1  one-cycle data completion pulse (read data or write ack)
StallF  output  1  IReq & ~IValid
StallM  output  1  DReq & ~DValid
MemEn  output  1  memory access strobe, one cycle per transaction
MemWe  output  1  memory write enable, qualified by MemEn
MemAddr  output  AW  memory address
MemWData  output  DW  memory write data
MemRData  input  DW  memory read data
Busy  output  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; owner/addr/data/counter regs 0; last-grant reg = I.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is pending, latch owner (D or I), addr, we, wdata at the edge and go to ISSUE.
  - Fixed priority: D wins over I (older instruction).
  - No request: stay in IDLE.
- ISSUE (1 cycle): MemEn=1; MemAddr/MemWe/MemWData driven from latched registers.
  - Write: go to RESP.
  - Read: counter := LAT-1, go to WAIT.
  - LAT=1 read: counter already 0, so WAIT lasts one cycle.
- WAIT: counter decrements. When counter==0, capture MemRData into the response register and go to RESP.
- RESP (1 cycle): if the owner's Req is still high, pulse the owner's Valid with registered data (DRData is don't-care for writes); go to IDLE.
  - If the owner's Req has dropped (flush), suppress Valid; any write already performed stands.
- Latency from request-sampling cycle t:
  - Read: Valid in cycle t+LAT+2.
  - Write: Valid in cycle t+2.
  - Throughput: one transaction per LAT+3 cycles (read) or 3 cycles (write).
- A Req still high in the cycle after Valid counts as a new request.
- The non-owner's Req is ignored until the next IDLE, and its stall stays high.
- StallF/StallM are combinational from Req and the Valid registers.
- MemEn is never high outside ISSUE. Memory outputs are 0 when not in ISSUE.
- Requester inputs are sampled only in IDLE; changes mid-transaction have no effect except Req in RESP.
- Reset mid-transaction: abort immediately to IDLE, no Valid. The memory sees at most the already-issued strobe.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: when IReq and DReq are both pending in IDLE, grant the requester not granted last. The last-grant reg updates on every grant; reset value I, so D wins the first contention. A single pending request is granted regardless.
- Undefined: fixed D-over-I priority, and the last-grant reg is not implemented.

Test Plan:
- Reset asserted mid-WAIT -> next cycle all outputs 0, Busy=0, no IValid/DValid ever pulses for the aborted transaction.
- IReq=1, IAddr=0x0010 at cycle t, memory returns 0xBEEF, LAT=2 -> MemEn=1 with MemAddr=0x0010, MemWe=0 only in t+1; IValid=1, IRData=0xBEEF in t+4; StallF=1 in t..t+3.
- DReq=1, DWe=1, DAddr=0x0020, DWData=0x1234 at t -> MemEn=MemWe=1, MemAddr=0x0020, MemWData=0x1234 in t+1; DValid=1 in t+2.
- IReq and DReq (read 0x0030 -> 0x5A5A) both at t, held -> D issued in t+1, DValid/DRData=0x5A5A in t+4; I issued in t+6, IValid in t+9; StallF high through t+8.
- IReq dropped during WAIT -> no IValid; Busy returns 0 after RESP; DReq raised in that IDLE cycle is issued on the next cycle.
- IReq and DReq held continuously, new requests each time after Valid -> grant order D,I,D,I with ARB_RR_EN; D,D,D without (IValid never pulses).
